// File: rtl/data_memory_responder.sv
// Data-memory responder: word-organised RAM serving byte/half/word loads and stores,
// splitting accesses that cross a word boundary into two consecutive word cycles.
module data_memory_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter     FILE_NAME   = ""
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_access,
  input  logic                  i_unsigned,
  input  logic                  i_wrEnable,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  output logic [DATA_WIDTH-1:0] o_rdData,
  output logic                  o_ack,
  output logic                  o_busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, SECOND} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] lo_word_q, lo_word_d;
  logic [IDX_W-1:0]      hi_idx_q, hi_idx_d;
  logic [3:0]            hi_be_q, hi_be_d;
  logic [DATA_WIDTH-1:0] hi_wdat_q, hi_wdat_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            access_q, access_d;
  logic                  uns_q, uns_d;
  logic                  we_q, we_d;

  logic [1:0]            off;
  logic [7:0]            size_mask;
  logic [7:0]            lane_mask;
  logic                  misaligned;
  logic [63:0]           wdata_wide;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      mem_idx;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdat;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [63:0]           assembled;
  logic [1:0]            sh_off;
  logic [DATA_WIDTH-1:0] load_raw;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^i_addr[ADDR_WIDTH-1:IDX_W+2];

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  acc,
                                              input logic        uns);
    logic [31:0] r;
    unique case (acc)
      2'b00:   r = {{24{~uns & raw[7]}}, raw[7:0]};
      2'b01:   r = {{16{~uns & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // Request decode: lanes spilling into mask[7:4] belong to the following word.
  always_comb begin
    off = i_addr[1:0];
    idx = i_addr[IDX_W+1:2];
    unique case (i_access)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      default: size_mask = 8'h0F;
    endcase
    lane_mask  = size_mask << off;
    misaligned = |lane_mask[7:4];
    wdata_wide = {32'd0, i_wrData} << {off, 3'b000};
  end

  assign mem_idx = (state_q == SECOND) ? hi_idx_q : idx;
  assign rd_word = mem[mem_idx];

  // Little-endian byte stream across both words, shifted down by the byte offset.
  always_comb begin
    assembled = (state_q == SECOND) ? {rd_word, lo_word_q} : {32'd0, rd_word};
    sh_off    = (state_q == SECOND) ? off_q : off;
    load_raw  = 32'(assembled >> {sh_off, 3'b000});
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_req && misaligned) state_d = SECOND;
      SECOND:  state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy    = (state_q == SECOND);
    ack_d     = 1'b0;
    rd_data_d = '0;
    mem_be    = '0;
    mem_wdat  = wdata_wide[31:0];
    lo_word_d = lo_word_q;
    hi_idx_d  = hi_idx_q;
    hi_be_d   = hi_be_q;
    hi_wdat_d = hi_wdat_q;
    off_d     = off_q;
    access_d  = access_q;
    uns_d     = uns_q;
    we_d      = we_q;
    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          if (i_wrEnable) mem_be = lane_mask[3:0];
          if (misaligned) begin
            lo_word_d = rd_word;
            hi_idx_d  = idx + IDX_W'(1);
            hi_be_d   = i_wrEnable ? lane_mask[7:4] : 4'b0000;
            hi_wdat_d = wdata_wide[63:32];
            off_d     = off;
            access_d  = i_access;
            uns_d     = i_unsigned;
            we_d      = i_wrEnable;
          end else begin
            ack_d = 1'b1;
            if (!i_wrEnable) rd_data_d = extend_load(load_raw, i_access, i_unsigned);
          end
        end
      end
      SECOND: begin
        ack_d    = 1'b1;
        mem_be   = hi_be_q;
        mem_wdat = hi_wdat_q;
        if (!we_q) rd_data_d = extend_load(load_raw, access_q, uns_q);
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ack_q     <= 1'b0;
      rd_data_q <= '0;
      lo_word_q <= '0;
      hi_idx_q  <= '0;
      hi_be_q   <= '0;
      hi_wdat_q <= '0;
      off_q     <= '0;
      access_q  <= '0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
      lo_word_q <= lo_word_d;
      hi_idx_q  <= hi_idx_d;
      hi_be_q   <= hi_be_d;
      hi_wdat_q <= hi_wdat_d;
      off_q     <= off_d;
      access_q  <= access_d;
      uns_q     <= uns_d;
      we_q      <= we_d;
    end
  end

  // Byte-lane write enables only; reset blocks writes so an abandoned access stops here.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  assign o_ack    = ack_q;
  assign o_rdData = rd_data_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed plan steps plus random accesses
// checked against a byte-addressed reference memory.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [1:0]  i_access;
  logic        i_unsigned;
  logic        i_wrEnable;
  logic [31:0] i_wrData;
  logic [31:0] o_rdData;
  logic        o_ack;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [4096];

  data_memory_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .FILE_NAME("")
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_req(i_req), .i_addr(i_addr),
    .i_access(i_access), .i_unsigned(i_unsigned), .i_wrEnable(i_wrEnable),
    .i_wrData(i_wrData), .o_rdData(o_rdData), .o_ack(o_ack), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] acc);
    return (acc == 2'b00) ? 1 : (acc == 2'b01) ? 2 : 4;
  endfunction

  // The RAM is 4 KiB; byte addresses wrap modulo its size.
  function automatic int byte_at(input logic [31:0] addr, input int k);
    return int'((addr + 32'(k)) & 32'h0000_0FFF);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] acc,
                                             input logic uns);
    int     n = size_of(acc);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(model_mem[byte_at(addr, k)]) << (8 * k);
    if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] acc, input logic [31:0] wd);
    for (int k = 0; k < size_of(acc); k++) model_mem[byte_at(addr, k)] = wd[8*k +: 8];
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] acc, input logic uns,
                       input logic we, input logic [31:0] wd);
    i_addr = addr; i_access = acc; i_unsigned = uns; i_wrEnable = we; i_wrData = wd;
  endtask

  // One complete access: checks busy, ack latency, load data and the ack dropping afterwards.
  task automatic do_access(input logic [31:0] addr, input logic [1:0] acc, input logic uns,
                           input logic we, input logic [31:0] wd);
    int          lat = 0;
    bit          mis = (int'(addr & 32'd3) + size_of(acc)) > 4;
    logic [31:0] exp = model_load(addr, acc, uns);
    @(negedge clk);
    drive(addr, acc, uns, we, wd);
    i_req = 1'b1;
    for (int c = 1; c <= 4 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (o_ack) lat = c;
      else if (c == 1) check("busy_in_second", {31'd0, o_busy}, {31'd0, mis});
    end
    check("ack_latency", lat, mis ? 2 : 1);
    check("busy_at_ack", {31'd0, o_busy}, 32'd0);
    if (lat != 0 && !we) check("load_data", o_rdData, exp);
    i_req = 1'b0;
    if (we) model_store(addr, acc, wd);
    @(posedge clk); #1;
    check("ack_single_pulse", {31'd0, o_ack}, 32'd0);
    check("rddata_zero_idle", o_rdData, 32'd0);
  endtask

  initial begin
    logic [31:0] e0, e1, e2;
    i_reset = 1'b1; i_req = 1'b0;
    drive(32'd0, 2'b10, 1'b0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'd0, o_ack}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_rddata", o_rdData, 32'd0);
    i_reset = 1'b0;

    // Known contents for the low and high regions used by the random phase.
    for (int w = 0; w <= 8; w++) do_access(32'(w * 4), 2'b10, 1'b0, 1'b1, $urandom);
    for (int w = 1016; w <= 1023; w++) do_access(32'(w * 4), 2'b10, 1'b0, 1'b1, $urandom);

    do_access(32'h100, 2'b10, 1'b0, 1'b1, 32'hDEADBEEF);
    do_access(32'h100, 2'b10, 1'b0, 1'b0, 32'd0);
    check("plan_word_value", model_load(32'h100, 2'b10, 1'b0), 32'hDEADBEEF);

    do_access(32'h100, 2'b10, 1'b0, 1'b1, 32'h0000_0000);
    do_access(32'h101, 2'b00, 1'b0, 1'b1, 32'h0000_0080);
    do_access(32'h100, 2'b10, 1'b0, 1'b0, 32'd0);
    do_access(32'h101, 2'b00, 1'b0, 1'b0, 32'd0);
    do_access(32'h101, 2'b00, 1'b1, 1'b0, 32'd0);
    do_access(32'h102, 2'b01, 1'b0, 1'b1, 32'h0000_8001);
    do_access(32'h102, 2'b01, 1'b0, 1'b0, 32'd0);

    do_access(32'h200, 2'b10, 1'b0, 1'b1, 32'h44332211);
    do_access(32'h204, 2'b10, 1'b0, 1'b1, 32'h88776655);
    do_access(32'h201, 2'b10, 1'b0, 1'b0, 32'd0);
    do_access(32'h203, 2'b10, 1'b0, 1'b1, 32'hAABBCCDD);
    do_access(32'h200, 2'b10, 1'b0, 1'b0, 32'd0);
    do_access(32'h204, 2'b10, 1'b0, 1'b0, 32'd0);

    do_access(32'hFFF, 2'b00, 1'b0, 1'b1, 32'h12);
    do_access(32'h000, 2'b00, 1'b0, 1'b1, 32'h34);
    do_access(32'hFFF, 2'b01, 1'b1, 1'b0, 32'd0);
    check("plan_wrap_value", model_load(32'hFFF, 2'b01, 1'b1), 32'h00003412);

    // Back-to-back aligned loads, new request presented in each ack cycle.
    e0 = model_load(32'h200, 2'b10, 1'b0);
    e1 = model_load(32'h101, 2'b00, 1'b0);
    e2 = model_load(32'h102, 2'b01, 1'b1);
    @(negedge clk);
    drive(32'h200, 2'b10, 1'b0, 1'b0, 32'd0); i_req = 1'b1;
    @(posedge clk); #1;
    check("b2b_ack0", {31'd0, o_ack}, 32'd1);
    check("b2b_data0", o_rdData, e0);
    drive(32'h101, 2'b00, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("b2b_ack1", {31'd0, o_ack}, 32'd1);
    check("b2b_data1", o_rdData, e1);
    drive(32'h102, 2'b01, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("b2b_ack2", {31'd0, o_ack}, 32'd1);
    check("b2b_data2", o_rdData, e2);
    i_req = 1'b0;
    @(posedge clk); #1;
    check("b2b_ack_end", {31'd0, o_ack}, 32'd0);

    // Reset during the second half of a misaligned store.
    do_access(32'h200, 2'b10, 1'b0, 1'b1, 32'h44332211);
    do_access(32'h204, 2'b10, 1'b0, 1'b1, 32'h88776655);
    @(negedge clk);
    drive(32'h203, 2'b10, 1'b0, 1'b1, 32'h556677CC); i_req = 1'b1;
    @(posedge clk); #1;
    check("rst_busy_before", {31'd0, o_busy}, 32'd1);
    check("rst_ack_before", {31'd0, o_ack}, 32'd0);
    i_reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ack", {31'd0, o_ack}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_rddata", o_rdData, 32'd0);
    i_reset = 1'b0; i_req = 1'b0;
    model_mem[32'h203] = 8'hCC;
    @(posedge clk); #1;
    check("rst_no_late_ack", {31'd0, o_ack}, 32'd0);
    do_access(32'h200, 2'b10, 1'b0, 1'b0, 32'd0);
    do_access(32'h204, 2'b10, 1'b0, 1'b0, 32'd0);
    check("rst_first_half_value", model_load(32'h200, 2'b10, 1'b0), 32'hCC332211);

    // Random accesses near both ends of the RAM, with junk in the ignored address bits.
    for (int t = 0; t < 200; t++) begin
      int          r  = $urandom_range(0, 63);
      logic [31:0] a  = (r < 32) ? 32'(r) : 32'(32'hFE0 + 32'(r - 32));
      a = ($urandom & 32'hFFFF_F000) | a;
      do_access(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
